// File: rtl/cntr_pkg.sv
// Shared constants for the counter family: direction, overflow mode and default width.
package cntr_pkg;

  localparam logic CNTR_DN   = 1'b0;
  localparam logic CNTR_UP   = 1'b1;

  localparam logic CNTR_WRAP = 1'b0;
  localparam logic CNTR_SAT  = 1'b1;

  localparam int unsigned CNTR_WIDTH = 4;

endpackage

// File: rtl/cntr_dff_reg.sv
// WIDTH-bit D register with asynchronous active-high reset to zero.
module cntr_dff_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, clear, terminal count and sticky overflow.
// Saturation is selectable through sat only when CNTR_SATURATE_EN is defined; otherwise it always wraps.
module param_updown_counter
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH   = CNTR_WIDTH,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] countbar,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             sat_mode;
  logic             at_max;
  logic             at_zero;

`ifdef CNTR_SATURATE_EN
  assign sat_mode = (sat == CNTR_SAT);
`else
  logic sat_unused;
  assign sat_unused = sat;
  assign sat_mode   = CNTR_WRAP;
`endif

  // Anything above MAX_VAL counts up as if it were MAX_VAL.
  assign at_max  = (count_q >= MAXV);
  assign at_zero = (count_q == '0);

  assign tc = en & (((up == CNTR_UP) & (count_q == MAXV)) |
                    ((up == CNTR_DN) & at_zero));

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      ovf_d = ovf_q | tc;
      if (up == CNTR_UP) begin
        if (at_max) count_d = sat_mode ? MAXV : '0;
        else        count_d = count_q + WIDTH'(1);
      end else begin
        if (at_zero) count_d = sat_mode ? '0 : MAXV;
        else         count_d = count_q - WIDTH'(1);
      end
    end
  end

  cntr_dff_reg #(.WIDTH(WIDTH)) u_count_reg (
    .clk (clk),
    .rst (rst),
    .d   (count_d),
    .q   (count_q)
  );

  cntr_dff_reg #(.WIDTH(1)) u_ovf_reg (
    .clk (clk),
    .rst (rst),
    .d   (ovf_d),
    .q   (ovf_q)
  );

  assign count    = count_q;
  assign countbar = ~count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: one instance at MAX_VAL=15, one at MAX_VAL=9.
module tb_param_updown_counter;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  logic         a_clr, a_load, a_en, a_up, a_sat;
  logic [W-1:0] a_load_val, a_count, a_countbar;
  logic         a_tc, a_ovf;

  logic         b_clr, b_load, b_en, b_up, b_sat;
  logic [W-1:0] b_load_val, b_count, b_countbar;
  logic         b_tc, b_ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(W), .MAX_VAL(15)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up(a_up), .sat(a_sat),
    .count(a_count), .countbar(a_countbar), .tc(a_tc), .ovf(a_ovf)
  );

  param_updown_counter #(.WIDTH(W), .MAX_VAL(9)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up(b_up), .sat(b_sat),
    .count(b_count), .countbar(b_countbar), .tc(b_tc), .ovf(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    {a_clr, a_load, a_en, a_up, a_sat} = '0;
    {b_clr, b_load, b_en, b_up, b_sat} = '0;
    a_load_val = '0;
    b_load_val = '0;
    #1;
    check("rst_count", a_count, 0);
    check("rst_countbar", a_countbar, 4'hF);
    check("rst_ovf", a_ovf, 0);
    check("rst_tc", a_tc, 0);

    // Count to 7, then reset asynchronously mid-cycle
    tick(1);
    rst = 1'b0;
    a_en = 1'b1; a_up = 1'b1;
    tick(7);
    check("a_at7", a_count, 7);
    #2 rst = 1'b1;
    #1;
    check("midrst_count", a_count, 0);
    check("midrst_countbar", a_countbar, 4'hF);
    check("midrst_ovf", a_ovf, 0);
    a_up = 1'b0;
    #1 check("rst_tc_down", a_tc, 1);
    a_up = 1'b1;
    #1 check("rst_tc_up", a_tc, 0);
    rst = 1'b0;
    tick(1);
    check("post_rst_first", a_count, 1);

    // MAX_VAL=15 with sat=1: wraps unless saturation is compiled in
    a_sat = 1'b1;
    tick(14);
    check("a_at15", a_count, 15);
    check("a_tc15", a_tc, 1);
    tick(1);
`ifdef CNTR_SATURATE_EN
    check("a_sat_hold15", a_count, 15);
`else
    check("a_macro_off_wrap", a_count, 0);
`endif
    check("a_ovf", a_ovf, 1);
    a_en = 1'b0;

    // MAX_VAL=9 wrap up
    b_en = 1'b1; b_up = 1'b1; b_sat = 1'b0;
    tick(9);
    check("b_at9", b_count, 9);
    check("b_tc9", b_tc, 1);
    check("b_ovf_before", b_ovf, 0);
    check("b_countbar9", b_countbar, 4'h6);
    tick(1);
    check("b_wrap_up", b_count, 0);
    check("b_ovf_up", b_ovf, 1);

    // Wrap down from 0
    b_clr = 1'b1;
    tick(1);
    check("b_clr_ovf", b_ovf, 0);
    b_clr = 1'b0; b_up = 1'b0;
    #1 check("b_tc_dn0", b_tc, 1);
    tick(1);
    check("b_wrap_dn", b_count, 9);
    check("b_ovf_dn", b_ovf, 1);

    // Down at 0 with sat=1
    b_clr = 1'b1;
    tick(1);
    b_clr = 1'b0; b_sat = 1'b1;
    tick(1);
`ifdef CNTR_SATURATE_EN
    check("b_sat_dn", b_count, 0);
    check("b_sat_tc", b_tc, 1);
`else
    check("b_sat_dn", b_count, 9);
    check("b_sat_tc", b_tc, 0);
`endif
    check("b_sat_ovf", b_ovf, 1);

    // Priority: clr over load over en, then load clamps to MAX_VAL
    b_sat = 1'b0; b_up = 1'b1;
    b_clr = 1'b1; b_load = 1'b1; b_load_val = 4'd5;
    tick(1);
    check("prio_clr_count", b_count, 0);
    check("prio_clr_ovf", b_ovf, 0);
    b_clr = 1'b0; b_load_val = 4'd12;
    tick(1);
    check("prio_load_clamp", b_count, 9);

    // Hold at 6 for 10 cycles
    b_load_val = 4'd6; b_en = 1'b0;
    tick(1);
    b_load = 1'b0;
    tick(10);
    check("hold_count", b_count, 6);
    check("hold_tc", b_tc, 0);

    // Direction reversal with no dead cycle
    b_en = 1'b1;
    tick(1);
    check("rev_up", b_count, 7);
    b_up = 1'b0;
    tick(1);
    check("rev_dn", b_count, 6);
    check("load_keeps_ovf", b_ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter. Successor to the 4-bit ripple counter: one clock domain instead of a ripple chain, with a configurable width and modulus, direction control, synchronous load and clear, terminal-count detection and a sticky overflow flag. Used as a general event, timeout and address counter in datapath and control blocks.

## Interface
- `WIDTH`, default 4: counter width in bits, ≥ 2.
- `MAX_VAL`, default 2**WIDTH-1: highest count value. Legal range 1..2**WIDTH-1.
- `clk` input, 1 bit: clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `clr` input, 1 bit: synchronous clear.
- `load` input, 1 bit: synchronous load strobe.
- `load_val` input, WIDTH bits: value taken on `load`.
- `en` input, 1 bit: count enable.
- `up` input, 1 bit: direction; 1 = increment, 0 = decrement.
- `sat` input, 1 bit: 1 = saturate at the limits, 0 = wrap.
- `count` output, WIDTH bits: registered count.
- `countbar` output, WIDTH bits: equal to `~count`.
- `tc` output, 1 bit: terminal count, combinational.
- `ovf` output, 1 bit: sticky overflow/underflow flag, registered.

## Operation
- **`rst` = 1:** `count` = 0 and `ovf` = 0 immediately, without waiting for a clock edge. Consequently `countbar` = all ones and `tc` = 0 unless `en` & ~`up`.
- **Priority at each edge:** `clr` > `load` > `en`.
  - `clr`: `count` ← 0, `ovf` ← 0.
  - `load`: `count` ← min(`load_val`, `MAX_VAL`). `ovf` is unchanged.
  - `en` & `up`:
    - If `count` < `MAX_VAL`: `count` ← `count`+1.
    - At `MAX_VAL`: `count` ← 0 when wrapping, holds at `MAX_VAL` when saturating.
  - `en` & ~`up`:
    - If `count` > 0: `count` ← `count`−1.
    - At 0: `count` ← `MAX_VAL` when wrapping, holds at 0 when saturating.
  - None of `clr`, `load`, `en` asserted: hold.
- **`tc`** = `en` & ((`up` & `count`==`MAX_VAL`) | (~`up` & `count`==0)). It does not depend on `clr`, `load` or `sat`.
- **`ovf`:** set on any edge where `tc`=1 and neither `clr` nor `load` is asserted. This applies in both wrap and saturate modes. Only `clr` or `rst` clears it.
- **Out-of-range count:** if `count` is ever above `MAX_VAL`, the next enabled up-count treats it as `MAX_VAL`.
- **Arithmetic:** all arithmetic is unsigned and WIDTH bits wide, with no carry beyond bit WIDTH−1. The `MAX_VAL` comparison is done at WIDTH bits.

## Timing
- `count` and `ovf` change one cycle after their inputs are sampled. Latency is 1 clock.
- `tc` is valid in the same cycle as the `count` and `en`/`up` that produce it.
- `rst` deassertion may be asynchronous to `clk`. The first count happens on the first rising edge after deassertion on which `en`=1.
- Reset asserted mid-count forces 0 at once. The counter restarts from 0 after release, and no partial increment is retained.
- Changing `up` between cycles reverses direction on the next edge with no dead cycle.

## Configuration
- **`CNTR_SATURATE_EN` defined:** the `sat` input selects saturate (1) or wrap (0), as described above.
- **`CNTR_SATURATE_EN` undefined:** saturation logic is compiled out. `sat` is ignored and the counter always wraps. The port stays present so instantiations do not change.

## Structure
- **Shared package `cntr_pkg`:**
  - Direction constants `CNTR_DN`=1'b0 and `CNTR_UP`=1'b1.
  - Mode constants `CNTR_WRAP`=1'b0 and `CNTR_SAT`=1'b1.
  - Default `CNTR_WIDTH`=4.
- **Sub-module `cntr_dff_reg`:** a WIDTH-parametrised D register with asynchronous active-high `rst` to 0. It is the generalisation of the team's existing D flip-flop. Both `count` and `ovf` are held in instances of it, and the next-state logic stays in the parent.

## Test plan
- Reset check, WIDTH=4, MAX_VAL=15: assert `rst` mid-count at 7 → `count`=0, `countbar`=4'hF and `ovf`=0 before the next edge. Release it with `en`=1, `up`=1 → 1 after one edge.
- Wrap up, MAX_VAL=9, `sat`=0: count 0→9 in 9 enabled cycles → `tc`=1 at 9, the next edge gives 0 and `ovf`=1.
- Wrap down from 0, MAX_VAL=9 → `count` becomes 9 and `ovf`=1. With `sat`=1 and the macro defined → holds at 0, `tc`=1, `ovf`=1.
- Priority: `clr`=`load`=`en`=1 with `load_val`=5 → `count`=0 and `ovf`=0. Then `load`=`en`=1 with `load_val`=12 and MAX_VAL=9 → `count`=9.
- Hold: `en`=0 for 10 cycles at 6 → `count` stays 6 and `tc`=0.
- Macro off: `sat`=1 at MAX_VAL=15 with `up`=1 → wraps to 0.
